// File: rtl/pico_timer_array_if.sv
// Picoblaze port bus between the processor (master) and the timer block (slave).
interface pico_timer_array_if;
  logic [7:0] port_id;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       read_strobe;
  logic       write_strobe;

  modport master (
    output port_id,
    output data_in,
    output read_strobe,
    output write_strobe,
    input  data_out
  );

  modport slave (
    input  port_id,
    input  data_in,
    input  read_strobe,
    input  write_strobe,
    output data_out
  );
endinterface

// File: rtl/pico_timer_array.sv
// NUM_TIMERS down-counters with one shared prescaler, a port-mapped register file
// and a combined registered interrupt for a Picoblaze processor.
module pico_timer_array #(
  parameter logic [7:0] BASE_ADDRESS = 8'h00,
  parameter int         NUM_TIMERS   = 2,
  parameter int         COUNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  pico_timer_array_if.slave     bus,
  output logic                  interrupt,
  output logic [NUM_TIMERS-1:0] timer_expired
);

  localparam int         NUM_BYTES = COUNT_WIDTH / 8;
  localparam logic [7:0] PRESC_REL = 8'(8 * NUM_TIMERS);

  logic [7:0]            rel_s;
  logic [2:0]            off_s;
  logic [7:0]            prescale_r;
  logic [7:0]            presc_cnt_r;
  logic                  tick_s;
  logic                  presc_wr_s;
  logic [7:0]            rd_s;
  logic [7:0]            chan_rd_s;
  logic [7:0]            data_out_r;
  logic                  interrupt_r;
  logic [NUM_TIMERS-1:0] chan_hit_s;
  logic [NUM_TIMERS-1:0] en_s;
  logic [NUM_TIMERS-1:0] one_shot_s;
  logic [NUM_TIMERS-1:0] irq_en_s;
  logic [NUM_TIMERS-1:0] expired_s;
  logic [7:0]            count_lo_s [NUM_TIMERS];
  logic [23:0]           snap_hi_s  [NUM_TIMERS];

  assign rel_s      = bus.port_id - BASE_ADDRESS;
  assign off_s      = rel_s[2:0];
  assign presc_wr_s = bus.write_strobe && (rel_s == PRESC_REL);
  assign tick_s     = (presc_cnt_r == prescale_r);

  // Byte 0 of the count is always live; upper bytes come from the snapshot so
  // a multi-byte read started at +2 is coherent.
  function automatic logic [7:0] chan_byte(
    input logic [2:0]  off,
    input logic [2:0]  ctrl,
    input logic        expired,
    input logic [7:0]  count_lo,
    input logic [23:0] snap_hi
  );
    logic [7:0] b;
    case (off)
      3'd0:    b = {5'b00000, ctrl};
      3'd1:    b = {7'b0000000, expired};
      3'd2:    b = count_lo;
      3'd3:    b = snap_hi[7:0];
      3'd4:    b = snap_hi[15:8];
      3'd5:    b = snap_hi[23:16];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  for (genvar c = 0; c < NUM_TIMERS; c++) begin : g_chan
    logic [COUNT_WIDTH-1:0] count_r;
    logic [COUNT_WIDTH-1:0] reload_r;
    logic [23:0]            snap_r;
    logic                   en_r;
    logic                   one_shot_r;
    logic                   irq_en_r;
    logic                   expired_r;
    logic                   wr_hit_s;
    logic                   ctrl_wr_s;
    logic                   clear_s;
    logic                   snap_rd_s;
    logic                   expire_s;

    assign chan_hit_s[c] = (rel_s < PRESC_REL) && (rel_s[7:3] == 5'(c));
    assign wr_hit_s      = bus.write_strobe && chan_hit_s[c];
    assign ctrl_wr_s     = wr_hit_s && (off_s == 3'd0);
    assign clear_s       = wr_hit_s && (off_s == 3'd1) && bus.data_in[0];
    assign snap_rd_s     = bus.read_strobe && chan_hit_s[c] && (off_s == 3'd2);
    assign expire_s      = en_r && tick_s && (count_r == {COUNT_WIDTH{1'b0}});

    // Channel countdown, sticky expiry flag, control, reload and snapshot registers
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        count_r    <= {COUNT_WIDTH{1'b0}};
        reload_r   <= {COUNT_WIDTH{1'b0}};
        snap_r     <= 24'h000000;
        en_r       <= 1'b0;
        one_shot_r <= 1'b0;
        irq_en_r   <= 1'b0;
        expired_r  <= 1'b0;
      end else begin
        if (en_r && tick_s) begin
          if (expire_s) begin
            if (one_shot_r) begin
              en_r <= 1'b0;
            end else begin
              count_r <= reload_r;
            end
          end else begin
            count_r <= count_r - COUNT_WIDTH'(1);
          end
        end
        // A hardware set on the same edge beats a software clear.
        if (expire_s) begin
          expired_r <= 1'b1;
        end else if (clear_s) begin
          expired_r <= 1'b0;
        end
        if (ctrl_wr_s) begin
          en_r       <= bus.data_in[0];
          one_shot_r <= bus.data_in[1];
          irq_en_r   <= bus.data_in[2];
          if (!en_r && bus.data_in[0]) begin
            count_r <= reload_r;
          end
        end
        for (int b = 0; b < NUM_BYTES; b++) begin
          if (wr_hit_s && (off_s == 3'(b + 2))) begin
            reload_r[8*b +: 8] <= bus.data_in;
          end
        end
        if (snap_rd_s) begin
          snap_r <= 24'(32'(count_r) >> 8);
        end
      end
    end

    assign en_s[c]       = en_r;
    assign one_shot_s[c] = one_shot_r;
    assign irq_en_s[c]   = irq_en_r;
    assign expired_s[c]  = expired_r;
    assign count_lo_s[c] = count_r[7:0];
    assign snap_hi_s[c]  = snap_r;
  end

  // Read-data mux: unmapped channels contribute zero, so an OR over channels selects
  always_comb begin
    chan_rd_s = 8'h00;
    for (int c = 0; c < NUM_TIMERS; c++) begin
      chan_rd_s = chan_rd_s | ({8{chan_hit_s[c]}} &
                  chan_byte(off_s, {irq_en_s[c], one_shot_s[c], en_s[c]},
                            expired_s[c], count_lo_s[c], snap_hi_s[c]));
    end
    if (rel_s == PRESC_REL) begin
      rd_s = prescale_r;
    end else begin
      rd_s = chan_rd_s;
    end
  end

  // Shared prescaler: counts 0..PRESCALE, restarted by any PRESCALE write
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prescale_r  <= 8'h00;
      presc_cnt_r <= 8'h00;
    end else if (presc_wr_s) begin
      prescale_r  <= bus.data_in;
      presc_cnt_r <= 8'h00;
    end else if (tick_s) begin
      presc_cnt_r <= 8'h00;
    end else begin
      presc_cnt_r <= presc_cnt_r + 8'd1;
    end
  end

  // Registered read data and combined interrupt
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out_r  <= 8'h00;
      interrupt_r <= 1'b0;
    end else begin
      data_out_r  <= rd_s;
      interrupt_r <= |(expired_s & irq_en_s);
    end
  end

  assign bus.data_out  = data_out_r;
  assign interrupt     = interrupt_r;
  assign timer_expired = expired_s;

endmodule

// File: tb/tb_pico_timer_array.sv
// Self-checking bench: directed scenarios plus random bus traffic against a
// cycle-level behavioural model of the timer array.
module tb_pico_timer_array;
  localparam int         NT   = 2;
  localparam int         CW   = 32;
  localparam logic [7:0] BASE = 8'h00;
  localparam logic [7:0] PRE  = 8'(BASE + 8'(8 * NT));

  logic          clk     = 1'b0;
  logic          reset_n = 1'b1;
  logic          interrupt;
  logic [NT-1:0] timer_expired;
  int            n_checks = 0;
  int            n_fails  = 0;
  int            cyc      = 0;

  pico_timer_array_if bus();

  pico_timer_array #(.BASE_ADDRESS(BASE), .NUM_TIMERS(NT), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus),
    .interrupt(interrupt), .timer_expired(timer_expired)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural model state
  logic [31:0] m_cnt [NT];
  logic [31:0] m_rel [NT];
  logic [31:0] m_snap[NT];
  bit          m_en  [NT];
  bit          m_os  [NT];
  bit          m_ie  [NT];
  bit          m_ex  [NT];
  logic [7:0]  m_pre, m_pcnt, m_dout;
  bit          m_int;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      if (n_fails <= 40) $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NT; k++) begin
      m_cnt[k] = 32'h0; m_rel[k] = 32'h0; m_snap[k] = 32'h0;
      m_en[k] = 1'b0; m_os[k] = 1'b0; m_ie[k] = 1'b0; m_ex[k] = 1'b0;
    end
    m_pre = 8'h00; m_pcnt = 8'h00; m_dout = 8'h00; m_int = 1'b0;
  endtask

  function automatic logic [7:0] model_read(input logic [7:0] a);
    int rel, c, o;
    rel = int'(8'(a - BASE));
    c = rel / 8;
    o = rel % 8;
    if (rel == 8 * NT) return m_pre;
    if (rel > 8 * NT) return 8'h00;
    case (o)
      0:       return {5'd0, m_ie[c], m_os[c], m_en[c]};
      1:       return {7'd0, m_ex[c]};
      2:       return m_cnt[c][7:0];
      3, 4, 5: return 8'(m_snap[c] >> (8 * (o - 2)));
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [NT-1:0] model_flags();
    logic [NT-1:0] f;
    for (int k = 0; k < NT; k++) f[k] = m_ex[k];
    return f;
  endfunction

  task automatic model_step();
    logic [7:0]  rd;
    logic [31:0] pre_cnt;
    bit          tick, irq, expire, en_pre, wr_hit, rd_hit;
    int          rel, o;
    rd  = model_read(bus.port_id);
    irq = 1'b0;
    for (int k = 0; k < NT; k++) irq = irq | (m_ex[k] & m_ie[k]);
    tick = (m_pcnt == m_pre);
    rel  = int'(8'(bus.port_id - BASE));
    o    = rel % 8;
    for (int k = 0; k < NT; k++) begin
      wr_hit  = bus.write_strobe && (rel / 8 == k);
      rd_hit  = bus.read_strobe && (rel / 8 == k) && (o == 2);
      pre_cnt = m_cnt[k];
      en_pre  = m_en[k];
      expire  = en_pre && tick && (pre_cnt == 32'h0);
      if (rd_hit) m_snap[k] = pre_cnt;
      if (en_pre && tick) begin
        if (expire) begin
          m_ex[k] = 1'b1;
          if (m_os[k]) m_en[k] = 1'b0;
          else m_cnt[k] = m_rel[k];
        end else begin
          m_cnt[k] = pre_cnt - 32'd1;
        end
      end
      if (wr_hit && o == 1 && bus.data_in[0] && !expire) m_ex[k] = 1'b0;
      if (wr_hit && o == 0) begin
        m_en[k] = bus.data_in[0]; m_os[k] = bus.data_in[1]; m_ie[k] = bus.data_in[2];
        if (!en_pre && bus.data_in[0]) m_cnt[k] = m_rel[k];
      end
      if (wr_hit && o >= 2 && o <= 5 && (o - 2) < CW / 8) m_rel[k][8*(o-2) +: 8] = bus.data_in;
    end
    if (bus.write_strobe && rel == 8 * NT) begin
      m_pre = bus.data_in; m_pcnt = 8'h00;
    end else if (tick) begin
      m_pcnt = 8'h00;
    end else begin
      m_pcnt = m_pcnt + 8'd1;
    end
    m_dout = rd;
    m_int  = irq;
  endtask

  initial forever begin
    @(posedge clk);
    if (!reset_n) model_reset();
    else model_step();
  end

  // Compare DUT outputs against the model every cycle, away from the active edge
  initial forever begin
    @(negedge clk);
    chk("data_out", 32'(bus.data_out), 32'(m_dout));
    chk("interrupt", 32'(interrupt), 32'(m_int));
    chk("timer_expired", 32'(timer_expired), 32'(model_flags()));
  end

  // Bus tasks: called and returning at posedge+2
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    bus.port_id = a; bus.data_in = d; bus.write_strobe = 1'b1;
    @(posedge clk); #2;
    bus.write_strobe = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] d);
    bus.port_id = a; bus.read_strobe = 1'b1;
    @(posedge clk); #2;
    bus.read_strobe = 1'b0;
    d = bus.data_out;
  endtask

  task automatic wait_flag(input int idx, output int t);
    t = -1;
    for (int i = 0; i < 40; i++) begin
      idle(1);
      if (timer_expired[idx]) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) begin
      n_checks++; n_fails++;
      $display("FAIL wait_flag%0d: no expiry within 40 cycles, required one", idx);
    end
  endtask

  initial begin
    logic [7:0]  d, b0, b1, b2, b3;
    int          t1, t2, t3, t4;
    bus.port_id = 8'hFF; bus.data_in = 8'h00;
    bus.read_strobe = 1'b0; bus.write_strobe = 1'b0;
    model_reset();
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;

    // Reset readback and CTRL masking
    for (int a = 0; a <= 8 * NT; a++) begin
      rd(8'(BASE + 8'(a)), d);
      chk("reset_read", 32'(d), 32'h00);
    end
    wr(BASE, 8'hFF);
    rd(BASE, d);
    chk("ctrl_mask", 32'(d), 32'h07);
    wr(BASE, 8'h00);
    wr(BASE + 8'd1, 8'h01);
    rd(8'h30, d);
    chk("unmapped_30", 32'(d), 32'h00);
    rd(PRE + 8'd1, d);
    chk("unmapped_pre1", 32'(d), 32'h00);

    // One-shot, RELOAD=3, prescale 0
    wr(PRE, 8'h00);
    wr(BASE + 8'd2, 8'h03); wr(BASE + 8'd3, 8'h00);
    wr(BASE + 8'd4, 8'h00); wr(BASE + 8'd5, 8'h00);
    wr(BASE, 8'h07);
    idle(3);
    chk("oneshot_not_yet", 32'(timer_expired[0]), 32'h0);
    idle(1);
    chk("oneshot_expired", 32'(timer_expired[0]), 32'h1);
    chk("oneshot_irq_lag", 32'(interrupt), 32'h0);
    idle(1);
    chk("oneshot_irq", 32'(interrupt), 32'h1);
    rd(BASE, d);
    chk("oneshot_ctrl", 32'(d), 32'h06);
    wr(BASE + 8'd1, 8'h01);
    chk("w1c_flag", 32'(timer_expired[0]), 32'h0);
    chk("w1c_irq_lag", 32'(interrupt), 32'h1);
    idle(1);
    chk("w1c_irq_low", 32'(interrupt), 32'h0);

    // Periodic channel 1, PRESCALE=4, RELOAD=1 -> period 10 clks
    wr(BASE + 8'd10, 8'h01); wr(BASE + 8'd11, 8'h00);
    wr(BASE + 8'd12, 8'h00); wr(BASE + 8'd13, 8'h00);
    wr(PRE, 8'h04);
    wr(BASE + 8'd8, 8'h05);
    wait_flag(1, t1);
    wr(BASE + 8'd9, 8'h01);
    wait_flag(1, t2);
    wr(BASE + 8'd9, 8'h01);
    wait_flag(1, t3);
    chk("period_1", 32'(t2 - t1), 32'd10);
    chk("period_2", 32'(t3 - t2), 32'd10);
    wr(BASE + 8'd9, 8'h00);
    chk("w0_no_clear", 32'(timer_expired[1]), 32'h1);
    wr(BASE + 8'd8, 8'h00);
    wr(BASE + 8'd9, 8'h01);

    // Coherent snapshot across the 16-bit rollover
    wr(BASE + 8'd2, 8'h00); wr(BASE + 8'd3, 8'h00);
    wr(BASE + 8'd4, 8'h01); wr(BASE + 8'd5, 8'h00);
    wr(PRE, 8'h00);
    wr(BASE, 8'h01);
    rd(BASE + 8'd2, b0); rd(BASE + 8'd3, b1); rd(BASE + 8'd4, b2); rd(BASE + 8'd5, b3);
    chk("snap_first", {b3, b2, b1, b0}, 32'h0001_0000);
    rd(BASE + 8'd2, b0); rd(BASE + 8'd3, b1); rd(BASE + 8'd4, b2); rd(BASE + 8'd5, b3);
    chk("snap_rollover", {b3, b2, b1, b0}, 32'h0000_FFFC);

    // W1C on the expiry edge, and a masked channel does not interrupt
    wr(BASE, 8'h00); wr(BASE + 8'd1, 8'h01);
    wr(BASE + 8'd8, 8'h04); wr(BASE + 8'd9, 8'h01);
    wr(BASE + 8'd2, 8'h02); wr(BASE + 8'd4, 8'h00);
    wr(BASE, 8'h01);
    idle(2);
    wr(BASE + 8'd1, 8'h01);
    chk("set_beats_clear", 32'(timer_expired[0]), 32'h1);
    idle(2);
    chk("masked_irq", 32'(interrupt), 32'h0);

    // Asynchronous reset with both channels running
    wr(BASE + 8'd8, 8'h05);
    idle(12);
    #1 reset_n = 1'b0;
    model_reset();
    #1;
    chk("arst_dout", 32'(bus.data_out), 32'h00);
    chk("arst_irq", 32'(interrupt), 32'h0);
    chk("arst_flags", 32'(timer_expired), 32'h0);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    idle(20);
    chk("post_reset_idle", 32'(timer_expired), 32'h0);
    rd(BASE + 8'd8, d);
    chk("post_reset_ctrl1", 32'(d), 32'h00);

    // Random bus traffic against the model
    for (int i = 0; i < 1500; i++) begin
      int unsigned op, a, o;
      logic [7:0] dv;
      op = $urandom_range(0, 9);
      a  = ($urandom_range(0, 31) == 0) ? 32'hC5 : $urandom_range(0, 8 * NT + 3);
      o  = a % 8;
      if (a == 8 * NT) dv = 8'($urandom_range(0, 3));
      else if (o == 2) dv = 8'($urandom_range(0, 6));
      else if (o >= 3 && o <= 5) dv = ($urandom_range(0, 15) == 0) ? 8'($urandom) : 8'h00;
      else dv = 8'($urandom);
      if (op < 6) wr(8'(BASE + 8'(a)), dv);
      else if (op < 9) rd(8'(BASE + 8'(a)), d);
      else idle(1);
    end
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
